// File: rtl/i2c_scl_generator.sv
// i2c_scl_generator: SCL bit-clock timing engine for the I2C master.
// Turns the clock-divider value into an open-drain SCL waveform. It also
// produces single-cycle phase strobes for the bit controller, and it follows
// slave clock stretching by watching the resolved bus line.
//
// Ports
//   pclk          system clock, all state on the rising edge
//   n_rst         asynchronous reset, active low
//   clk_div       pclk cycles per SCL half-period (0 and 1 are clamped to 2)
//   enable        level request to keep SCL running
//   scl_in        resolved SCL bus level (asynchronous)
//   scl_oe        1 = pull SCL low, 0 = release
//   fall_strobe   first cycle of each low phase
//   drive_strobe  mid-low; the controller updates SDA here
//   rise_strobe   first cycle of each counted high phase
//   sample_strobe mid-high; the controller samples SDA here
//   stretching    SCL is released but not yet seen high
//   busy          block is not idle
module i2c_scl_generator #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 pclk,
  input  logic                 n_rst,
  input  logic [CNT_WIDTH-1:0] clk_div,
  input  logic                 enable,
  input  logic                 scl_in,
  output logic                 scl_oe,
  output logic                 fall_strobe,
  output logic                 drive_strobe,
  output logic                 rise_strobe,
  output logic                 sample_strobe,
  output logic                 stretching,
  output logic                 busy
);

  localparam int unsigned MIN_HALF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH_WAIT,
    ST_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] h_q, h_d;
  logic [CNT_WIDTH-1:0] h_eff;
  logic [CNT_WIDTH-1:0] h_last;
  logic [CNT_WIDTH-1:0] half_d;
  logic                 scl_meta, scl_sync;
  logic                 scl_high;

  // Two-flop synchronizer on the bus line; idles high like a released bus.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
    end
  end

  // The state register acts on the value the second stage is loading, so
  // HIGH starts together with scl_sync going high. This keeps the
  // unstretched wait at two cycles. scl_sync being already high only
  // confirms a level that was seen earlier.
  assign scl_high = scl_meta | scl_sync;

  // Half-period with the lower clamp applied.
  assign h_eff  = (clk_div < CNT_WIDTH'(MIN_HALF)) ? CNT_WIDTH'(MIN_HALF) : clk_div;
  assign h_last = h_q - CNT_WIDTH'(1);

  // State, counter and latched half-period registers.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      h_q     <= CNT_WIDTH'(MIN_HALF);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      h_q     <= h_d;
    end
  end

  // Next-state logic. h is reloaded only on entry to LOW or HIGH, so a
  // divisor change takes effect from the next half-phase.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    h_d     = h_q;
    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (enable) begin
          state_d = ST_LOW;
          h_d     = h_eff;
        end
      end
      ST_LOW: begin
        if (count_q == h_last) begin
          state_d = ST_HIGH_WAIT;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      ST_HIGH_WAIT: begin
        count_d = '0;
        if (scl_high) begin
          state_d = ST_HIGH;
          h_d     = h_eff;
        end
      end
      ST_HIGH: begin
        if (count_q == h_last) begin
          count_d = '0;
          if (enable) begin
            state_d = ST_LOW;
            h_d     = h_eff;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    half_d = h_d >> 1;
  end

  // Outputs are registered from the next state and count. Each one then
  // matches a decode of the registered state and count, and the pad enable
  // comes straight from a flop.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      scl_oe        <= 1'b0;
      fall_strobe   <= 1'b0;
      drive_strobe  <= 1'b0;
      rise_strobe   <= 1'b0;
      sample_strobe <= 1'b0;
      stretching    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      scl_oe        <= (state_d == ST_LOW);
      fall_strobe   <= (state_d == ST_LOW)  && (count_d == '0);
      drive_strobe  <= (state_d == ST_LOW)  && (count_d == half_d);
      rise_strobe   <= (state_d == ST_HIGH) && (count_d == '0);
      sample_strobe <= (state_d == ST_HIGH) && (count_d == half_d);
      stretching    <= (state_d == ST_HIGH_WAIT);
      busy          <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Testbench for i2c_scl_generator.
// A phase-level model walks the expected waveform one cycle at a time:
// H low cycles, then 2 + stretch wait cycles, then H high cycles.
// Each cycle it checks the whole output vector.
module tb_i2c_scl_generator;

  localparam int unsigned CW = 32;

  logic          pclk;
  logic          n_rst;
  logic [CW-1:0] clk_div;
  logic          enable;
  logic          scl_in;
  logic          scl_oe;
  logic          fall_strobe;
  logic          drive_strobe;
  logic          rise_strobe;
  logic          sample_strobe;
  logic          stretching;
  logic          busy;
  logic          hold;

  int n_checks;
  int n_fails;

  i2c_scl_generator #(.CNT_WIDTH(CW)) dut (
    .pclk          (pclk),
    .n_rst         (n_rst),
    .clk_div       (clk_div),
    .enable        (enable),
    .scl_in        (scl_in),
    .scl_oe        (scl_oe),
    .fall_strobe   (fall_strobe),
    .drive_strobe  (drive_strobe),
    .rise_strobe   (rise_strobe),
    .sample_strobe (sample_strobe),
    .stretching    (stretching),
    .busy          (busy)
  );

  // Open-drain bus: low when the master drives it or a slave holds it.
  assign scl_in = ~scl_oe & ~hold;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  localparam logic [6:0] IDLE_V = 7'b0000000;

  function automatic int eff(input logic [CW-1:0] d);
    return (d < 2) ? 2 : int'(d);
  endfunction

  function automatic logic [6:0] v(input bit oe, input bit fall, input bit drv,
                                   input bit rise, input bit smp, input bit str,
                                   input bit bsy);
    return {oe, fall, drv, rise, smp, str, bsy};
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {scl_oe, fall_strobe, drive_strobe, rise_strobe, sample_strobe, stretching, busy};
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b (oe,fall,drive,rise,sample,stretch,busy)",
             tag, obs, exp);
    end
  endtask

  // Walk one SCL period. The walk starts in low cycle 0 and ends one cycle
  // after the last high cycle. chg_at / stop_at / restart_at are cycle
  // indices (-1 = unused) at which clk_div changes, enable drops
  // (low phase) or enable rises again (high phase).
  task automatic period(input string tag, input int hl, input int k,
                        input int chg_at, input logic [CW-1:0] chg_val,
                        input int stop_at, input int restart_at,
                        output int hh);
    hold = 1'b1;
    for (int i = 0; i < hl; i++) begin
      chk($sformatf("%s_low%0d", tag, i), v(1, i == 0, i == hl / 2, 0, 0, 0, 1));
      if (i == chg_at) clk_div = chg_val;
      if (i == stop_at) enable = 1'b0;
      step();
    end
    hh = eff(clk_div);
    for (int j = 0; j < k + 2; j++) begin
      chk($sformatf("%s_wait%0d", tag, j), v(0, 0, 0, 0, 0, 1, 1));
      if (j == k) hold = 1'b0;
      step();
    end
    for (int i = 0; i < hh; i++) begin
      chk($sformatf("%s_high%0d", tag, i), v(0, 0, 0, i == 0, i == hh / 2, 0, 1));
      if (i == restart_at) enable = 1'b1;
      step();
    end
  endtask

  initial begin
    int hl;
    int hh;
    int d;
    int k;
    n_checks = 0;
    n_fails  = 0;
    n_rst    = 1'b0;
    enable   = 1'b0;
    clk_div  = CW'(10);
    hold     = 1'b0;

    #1;
    chk("reset_state", IDLE_V);
    #21;
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_after_reset%0d", i), IDLE_V);
    end

    // Start: enable is sampled at the next edge, LOW is visible after it.
    enable = 1'b1;
    chk("start_not_yet", IDLE_V);
    step();

    // Nominal periods with clk_div = 10: period of 22 cycles.
    for (int p = 0; p < 2; p++) period($sformatf("nom%0d", p), 10, 0, -1, '0, -1, -1, hh);

    // Slave holds SCL low for 20 extra cycles.
    period("stretch", 10, 20, -1, '0, -1, -1, hh);

    // Divisor change mid-low: this low is 10 cycles, the following high is 4.
    period("divchg", 10, 0, 2, CW'(4), -1, -1, hh);

    // Clamp: 0 and 1 both give 2-cycle halves.
    period("clamp_a", hh, 0, 0, CW'(0), -1, -1, hh);
    period("clamp_b", hh, 0, 0, CW'(1), -1, -1, hh);
    period("clamp_c", hh, 0, -1, '0, -1, -1, hh);

    // enable drops and rises within one period: no idle gap.
    period("bounce", hh, 0, -1, '0, 0, 1, hh);

    // Random divisors and stretch lengths.
    hl = hh;
    for (int r = 0; r < 8; r++) begin
      d = int'($urandom_range(0, 12));
      k = int'($urandom_range(0, 4));
      period($sformatf("rnd%0d", r), hl, k, 0, CW'(d), -1, -1, hh);
      hl = hh;
    end

    // Graceful stop at low cycle 3 with clk_div = 8.
    period("pre_stop", hl, 0, 0, CW'(8), -1, -1, hh);
    period("stop", hh, 0, -1, '0, 3, -1, hh);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stopped%0d", i), IDLE_V);
      step();
    end

    // Reset in the middle of a low phase releases SCL at once.
    enable = 1'b1;
    step();
    chk("rst_low0", v(1, 1, 0, 0, 0, 0, 1));
    step();
    step();
    #2;
    n_rst = 1'b0;
    #1;
    chk("reset_mid_low", IDLE_V);
    enable = 1'b0;
    #3;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("idle_after_rst2_%0d", i), IDLE_V);
    end
    enable = 1'b1;
    step();
    period("after_rst", eff(clk_div), 0, -1, '0, 0, -1, hh);
    chk("final_idle", IDLE_V);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
